// File: rtl/apb_dac_control.sv
// APB slave streaming CPU-written samples to the DAC through a TX FIFO with a pacing counter.
// Optional FIFO replay (loop) mode is built only when DAC_LOOP_EN is defined.
module apb_dac_control #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 10,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                      pclk,
  input  logic                      prst_n,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]               pwdata,
  input  logic                      pwrite,
  input  logic                      psel,
  input  logic                      penable,
  output logic [31:0]               prdata,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     dac_data,
  output logic                      dac_load,
  output logic                      dac_pd,
  output logic                      dac_low_interrupt,
  output logic                      dac_empty_interrupt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [APB_ADDR_WIDTH-1:0] A_CFG   = APB_ADDR_WIDTH'(8'h00);
  localparam logic [APB_ADDR_WIDTH-1:0] A_DIV   = APB_ADDR_WIDTH'(8'h04);
  localparam logic [APB_ADDR_WIDTH-1:0] A_THR   = APB_ADDR_WIDTH'(8'h08);
  localparam logic [APB_ADDR_WIDTH-1:0] A_CTL   = APB_ADDR_WIDTH'(8'h0C);
  localparam logic [APB_ADDR_WIDTH-1:0] A_DATA  = APB_ADDR_WIDTH'(8'h10);
  localparam logic [APB_ADDR_WIDTH-1:0] A_STATE = APB_ADDR_WIDTH'(8'h14);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q, state_d;
  logic                  pd_q, pd_d;
  logic [15:0]           div_q, div_d, thr_q, thr_d, pace_q, pace_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         rptr_q, rptr_d, wptr_q, wptr_d;
  logic                  over_q, over_d, under_q, under_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  load_q, load_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic wr, wr_cfg, wr_div, wr_thr, wr_ctl, wr_data, wr_state;
  logic running, empty, full, pace_zero, flush;
  logic pop, wb, push_acc, push_rej, wen, loop_act, loop_rd;
  logic [DATA_WIDTH-1:0] head, wdata;
  logic unused_pwdata;

  assign wr       = psel & pwrite & penable;
  assign wr_cfg   = wr && (paddr == A_CFG);
  assign wr_div   = wr && (paddr == A_DIV);
  assign wr_thr   = wr && (paddr == A_THR);
  assign wr_ctl   = wr && (paddr == A_CTL);
  assign wr_data  = wr && (paddr == A_DATA);
  assign wr_state = wr && (paddr == A_STATE);
  assign unused_pwdata = ^pwdata[31:16];

  assign running   = (state_q == RUN);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign pace_zero = (pace_q == '0);
  assign flush     = wr_ctl & pwdata[1];
  assign head      = mem_q[rptr_q];

`ifdef DAC_LOOP_EN
  logic loop_q;
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n)     loop_q <= 1'b0;
    else if (wr_cfg) loop_q <= pwdata[0];
  end
  assign loop_act = running & loop_q;
  assign loop_rd  = loop_q;
`else
  assign loop_act = 1'b0;
  assign loop_rd  = 1'b0;
`endif

  // Flush wins over everything; a full FIFO still accepts a push when a pop frees a slot.
  assign pop      = running & pace_zero & ~empty & ~flush;
  assign wb       = pop & loop_act;
  assign push_acc = wr_data & ~flush & ~loop_act & (~full | pop);
  assign push_rej = wr_data & ~flush & (loop_act | (full & ~pop));
  assign wen      = push_acc | wb;
  assign wdata    = wb ? head : pwdata[DATA_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    if (wr_ctl) state_d = pwdata[0] ? RUN : IDLE;
  end

  always_comb begin
    pd_d    = pd_q;
    div_d   = div_q;
    thr_d   = thr_q;
    over_d  = over_q;
    under_d = under_q;
    data_d  = data_q;
    load_d  = pop;
    pace_d  = '0;
    count_d = count_q + CW'(push_acc) - CW'(pop & ~wb);
    rptr_d  = rptr_q + AW'(pop);
    wptr_d  = wptr_q + AW'(wen);
    if (wr_cfg) pd_d  = pwdata[1];
    if (wr_div) div_d = pwdata[15:0];
    if (wr_thr) thr_d = pwdata[15:0];
    if (wr_state && pwdata[2]) over_d  = 1'b0;
    if (wr_state && pwdata[3]) under_d = 1'b0;
    if (push_rej) over_d = 1'b1;
    if (running) begin
      pace_d = pace_zero ? div_q : pace_q - 16'd1;
      if (pace_zero && empty) under_d = 1'b1;
    end
    if (pop) data_d = head;
    if (flush) begin
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q <= IDLE;
      pd_q    <= 1'b1;
      div_q   <= '0;
      thr_q   <= 16'(FIFO_DEPTH / 2);
      pace_q  <= '0;
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
      data_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pd_q    <= pd_d;
      div_q   <= div_d;
      thr_q   <= thr_d;
      pace_q  <= pace_d;
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      over_q  <= over_d;
      under_q <= under_d;
      data_q  <= data_d;
      load_q  <= load_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge pclk) begin
    if (wen) mem_q[wptr_q] <= wdata;
  end

  always_comb begin
    prdata = '0;
    case (paddr)
      A_CFG:   prdata = {30'b0, pd_q, loop_rd};
      A_DIV:   prdata = {16'b0, div_q};
      A_THR:   prdata = {16'b0, thr_q};
      A_CTL:   prdata = {31'b0, running};
      A_DATA:  prdata = 32'(data_q);
      A_STATE: prdata = {16'(count_q), 12'b0, under_q, over_q, empty, full};
      default: prdata = '0;
    endcase
  end

  assign pready              = 1'b1;
  assign dac_data            = data_q;
  assign dac_load            = load_q;
  assign dac_pd              = pd_q;
  assign dac_low_interrupt   = running & (16'(count_q) <= thr_q);
  assign dac_empty_interrupt = under_q;
endmodule

// File: tb/tb_apb_dac_control.sv
// Directed bench for apb_dac_control: scoreboard queue checks every dac_load strobe.
module tb_apb_dac_control;
  localparam int AWID = 12;
  localparam int DW   = 10;
  localparam int DEP  = 16;

  logic            pclk = 1'b0;
  logic            prst_n;
  logic [AWID-1:0] paddr;
  logic [31:0]     pwdata, prdata;
  logic            pwrite, psel, penable, pready;
  logic [DW-1:0]   dac_data;
  logic            dac_load, dac_pd, dac_low_interrupt, dac_empty_interrupt;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW-1:0] sbq[$];
  bit            sb_strict = 1'b1;
  logic [31:0]   rd;

  apb_dac_control #(.APB_ADDR_WIDTH(AWID), .DATA_WIDTH(DW), .FIFO_DEPTH(DEP)) dut (
    .pclk(pclk), .prst_n(prst_n), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready),
    .dac_data(dac_data), .dac_load(dac_load), .dac_pd(dac_pd),
    .dac_low_interrupt(dac_low_interrupt), .dac_empty_interrupt(dac_empty_interrupt)
  );

  always #5 pclk = ~pclk;

  // Every strobe must deliver the oldest expected sample.
  always @(negedge pclk) begin
    if (prst_n && dac_load && (sb_strict || sbq.size() > 0)) begin
      n_chk++;
      assert (sbq.size() > 0 && dac_data === sbq[0]) else begin
        n_fail++;
        $error("FAIL dac_sample: observed %0h expected %0h", dac_data,
               (sbq.size() > 0) ? sbq[0] : 'x);
      end
      if (sbq.size() > 0) void'(sbq.pop_front());
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input logic [AWID-1:0] a, input logic [31:0] d);
    @(negedge pclk);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [AWID-1:0] a, output logic [31:0] d);
    @(negedge pclk);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1 d = prdata;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] v, input bit expect_out);
    apb_wr(12'h10, 32'(v));
    if (expect_out) sbq.push_back(v);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && sbq.size() > 0; i++) @(negedge pclk);
    chk(tag, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    prst_n = 1'b0; paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
    repeat (2) @(negedge pclk);
    prst_n = 1'b1;

    // Reset state
    @(negedge pclk);
    chk("rst_pd", 32'(dac_pd), 32'd1);
    chk("rst_data", 32'(dac_data), 32'd0);
    chk("rst_load", 32'(dac_load), 32'd0);
    chk("rst_irq", {30'b0, dac_low_interrupt, dac_empty_interrupt}, 32'd0);
    chk("pready", 32'(pready), 32'd1);
    apb_rd(12'h14, rd); chk("rst_state", rd, 32'h0000_0002);
    apb_rd(12'h00, rd); chk("rst_cfg", rd, 32'h2);
    apb_rd(12'h08, rd); chk("rst_thr", rd, 32'(DEP / 2));
    apb_rd(12'h40, rd); chk("unmapped_rd", rd, 32'h0);

    // Paced stream of three samples, then underrun
    apb_wr(12'h00, 32'h0);
    push(10'h011, 1); push(10'h022, 1); push(10'h033, 1);
    apb_wr(12'h04, 32'd3);
    apb_wr(12'h0C, 32'h1);
    chk("load_t1", 32'(dac_load), 32'd0);
    for (int c = 2; c <= 14; c++) begin
      @(negedge pclk);
      chk($sformatf("load_t%0d", c), 32'(dac_load), 32'(c == 2 || c == 6 || c == 10));
      chk($sformatf("under_t%0d", c), 32'(dac_empty_interrupt), 32'(c >= 14));
    end
    chk("sb_empty_a", 32'(sbq.size()), 32'd0);
    apb_wr(12'h0C, 32'h0);
    apb_wr(12'h14, 32'h8);
    chk("under_clr", 32'(dac_empty_interrupt), 32'd0);
    apb_rd(12'h14, rd); chk("state_a", rd, 32'h0000_0002);

    // Overflow: 17 pushes into 16 entries
    for (int i = 0; i < 17; i++) push(DW'(10'h040 + i), i < 16);
    apb_rd(12'h14, rd); chk("state_full", rd, 32'h0010_0005);
    apb_wr(12'h14, 32'h4);
    apb_rd(12'h14, rd); chk("over_clr", rd, 32'h0010_0001);

    // Full FIFO, DIV=0: push in the first pop cycle is accepted
    apb_wr(12'h04, 32'd0);
    @(negedge pclk);
    paddr = 12'h0C; pwdata = 32'h1; pwrite = 1'b1; psel = 1'b1; penable = 1'b1;
    @(negedge pclk);
    paddr = 12'h10; pwdata = 32'h3AA;
    sbq.push_back(10'h3AA);
    @(negedge pclk);
    paddr = 12'h14; pwrite = 1'b0; penable = 1'b0;
    #1 chk("state_pushpop", prdata, 32'h0010_0001);
    psel = 1'b0;
    drain("drain_c", 60);
    apb_wr(12'h0C, 32'h0);
    apb_wr(12'h14, 32'hC);

    // Low-water interrupt, flush while running, stop
    apb_wr(12'h08, 32'd4);
    apb_wr(12'h04, 32'd3);
    for (int i = 0; i < 8; i++) push(DW'(10'h080 + i), 1);
    chk("low_idle", 32'(dac_low_interrupt), 32'd0);
    apb_wr(12'h0C, 32'h1);
    for (int c = 2; c <= 14; c++) begin
      @(negedge pclk);
      chk($sformatf("low_t%0d", c), 32'(dac_low_interrupt), 32'(c >= 14));
    end
    apb_wr(12'h0C, 32'h3);
    sbq.delete();
    chk("low_flush", 32'(dac_low_interrupt), 32'd1);
    apb_rd(12'h14, rd); chk("state_flush", rd & 32'hFFFF_0003, 32'h0000_0002);
    apb_rd(12'h0C, rd); chk("ctl_run_kept", rd, 32'h1);
    apb_wr(12'h0C, 32'h0);
    chk("low_stop", 32'(dac_low_interrupt), 32'd0);
    apb_wr(12'h14, 32'hC);

`ifdef DAC_LOOP_EN
    // Replay mode: two-entry waveform repeats, DATA writes rejected
    apb_wr(12'h00, 32'h1);
    push(10'h100, 0); push(10'h200, 0);
    apb_wr(12'h04, 32'd1);
    for (int i = 0; i < 3; i++) begin sbq.push_back(10'h100); sbq.push_back(10'h200); end
    sb_strict = 1'b0;
    apb_wr(12'h0C, 32'h1);
    drain("drain_loop", 40);
    apb_wr(12'h10, 32'h155);
    apb_rd(12'h14, rd); chk("state_loop", rd & 32'hFFFF_0004, 32'h0002_0004);
    apb_wr(12'h0C, 32'h0);
    repeat (3) @(negedge pclk);
    sbq.delete();
    sb_strict = 1'b1;
`else
    apb_wr(12'h00, 32'h3);
    apb_rd(12'h00, rd); chk("cfg_loop_ro", rd, 32'h2);
    apb_wr(12'h00, 32'h0);
`endif

    // Async reset discards FIFO contents and output state
    push(10'h155, 0); push(10'h2AA, 0);
    @(negedge pclk);
    #2 prst_n = 1'b0;
    #1 chk("arst_data", 32'(dac_data), 32'd0);
    chk("arst_pd", 32'(dac_pd), 32'd1);
    @(negedge pclk);
    prst_n = 1'b1;
    apb_rd(12'h14, rd); chk("arst_state", rd, 32'h0000_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_dac_control.md
Name: apb_dac_control

Overview:
APB slave that streams CPU-written samples out to the on-chip DAC. It is the transmit counterpart of the ADC capture block and uses the same base-address register style. Software pushes samples into a TX FIFO. A pclk-derived pacing counter pops one sample every DIV+1 cycles onto the DAC data bus and pulses a load strobe. Low-water and underrun interrupts go to the event unit. Single clock domain (pclk).

Parameters:
APB_ADDR_WIDTH, 12, APB address width (4KB slave window)
DATA_WIDTH, 10, DAC sample width
FIFO_DEPTH, 16, TX FIFO entries (power of 2, >=4)

Ports:
pclk  in  1  APB/system clock
prst_n  in  1  async active-low reset
paddr  in  APB_ADDR_WIDTH  APB address
pwdata  in  32  APB write data
pwrite  in  1  APB write
psel  in  1  APB select
penable  in  1  APB enable
prdata  out  32  APB read data
pready  out  1  tied 1
dac_data  out  DATA_WIDTH  sample to DAC
dac_load  out  1  one-cycle strobe, dac_data valid
dac_pd  out  1  DAC power-down
dac_low_interrupt  out  1  FIFO at/below threshold while running
dac_empty_interrupt  out  1  sticky underrun

Behaviour:
- Reset and clock: prst_n is asynchronous, active-low; all flops are clocked on pclk.
- Write strobe = psel&pwrite&penable. prdata is a combinational decode of paddr. Unmapped reads return 0. Unmapped writes are ignored (no register reset).
- Register 0x00 CFG: [0] loop, [1] pd (reset 1). Drives dac_pd.
- Register 0x04 DIV: [15:0], reset 0.
- Register 0x08 THR: [15:0] low-water level, reset FIFO_DEPTH/2.
- Register 0x0C CTL: [0] run (reset 0); [1] flush (write-1, self-clearing, reads 0).
- Register 0x10 DATA: a write pushes pwdata[DATA_WIDTH-1:0]; a read returns the current dac_data.
- Register 0x14 STATE: [31:16] count, [3] underrun, [2] overflow, [1] empty, [0] full. Writing 1 to bit 3 or bit 2 clears that flag.
- Reset values: dac_data 0, dac_load 0, dac_pd 1, both interrupts 0, FIFO empty, state IDLE.
- FSM IDLE: no pops. A write of CTL.run=1 moves to RUN on the next edge with pace counter=0.
- FSM RUN: counter nonzero -> decrement. Counter==0 and FIFO not empty -> pop. The next edge sets dac_data=head and dac_load=1 for exactly one cycle, and reloads the counter with DIV.
- FSM RUN, underrun: counter==0 and FIFO empty -> no strobe, dac_data holds, underrun<=1, counter reloads with DIV.
- FSM RUN, stop: CTL.run=0 -> IDLE on the next edge. FIFO contents and dac_data are kept. A pop already scheduled in that cycle still completes.
- Timing: CTL.run=1 written in cycle T -> first dac_load in cycle T+2, then every DIV+1 cycles. DIV=0 gives a strobe every cycle while data is available.
- Push rules: accepted if not full, or if a pop happens in the same cycle. A rejected push sets overflow and drops the data.
- Pop rules: occurs only if the FIFO is non-empty before any same-cycle push. There is no bypass.
- Flush: empties the FIFO and zeroes count. It takes priority over a same-cycle push or pop and does not change run state.
- count is 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- dac_low_interrupt = RUN & (count <= THR), level-sensitive.
- dac_empty_interrupt = underrun flag.
- Async reset mid-stream: all state returns to reset values immediately and FIFO data is discarded.

Optional Feature:
Macro DAC_LOOP_EN.
- Defined: CFG.loop=1 in RUN makes each pop write the same word back to the tail in the same cycle, so count is unchanged and the FIFO replays as a periodic waveform. APB DATA writes in RUN with loop=1 are dropped and set overflow. An empty FIFO in loop mode still underruns.
- Undefined: CFG[0] is read-only 0 and all loop logic is absent.

Test Plan:
- Reset -> dac_pd=1, dac_data=0, STATE=0x0000_0002, CFG=0x2, THR=FIFO_DEPTH/2, no dac_load.
- Push 0x011,0x022,0x033, DIV=3, run=1 at T -> dac_load at T+2, T+6, T+10 with dac_data 0x011/0x022/0x033. At T+14 underrun=1 and dac_empty_interrupt=1 with no strobe. Writing 0x8 to STATE clears it.
- Push 17 words into depth 16 -> full=1 and overflow=1, count=16, 17th word never output.
- Full FIFO, DIV=0, RUN, DATA write in a pop cycle -> push accepted, count stays 16, overflow stays 0.
- THR=4, run with 8 entries -> dac_low_interrupt rises on the cycle count becomes 4. Flush sets count=0 and empty=1 and keeps it high. run=0 drops it next cycle.
- DAC_LOOP_EN, CFG=0x1, push 0x100,0x200, DIV=1 -> strobes alternate 0x100,0x200 indefinitely, count=2. A DATA write sets overflow.
